// File: rtl/easy_axi_slv.sv
// easy_axi_slv: AR/R read slave; in-order single-beat responses RD_LATENCY+1 cycles after acceptance, held while rready=0.
// Optional `EASY_AXI_SLV_ALIGN_CHECK_EN: misaligned addresses return SLVERR with zero data.

`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 4
`endif
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 32
`endif

module easy_axi_slv #(
  parameter int QUEUE_DEPTH = 4,
  parameter int RD_LATENCY  = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          axi_slv_arvalid,
  output logic                          axi_slv_arready,
  input  logic [`AXI_ID_WIDTH-1:0]      axi_slv_arid,
  input  logic [`AXI_ADDR_WIDTH-1:0]    axi_slv_araddr,
  output logic                          axi_slv_rvalid,
  input  logic                          axi_slv_rready,
  output logic [`AXI_ID_WIDTH-1:0]      axi_slv_rid,
  output logic [`AXI_DATA_WIDTH-1:0]    axi_slv_rdata,
  output logic [1:0]                    axi_slv_rresp,
  output logic                          axi_slv_rlast,
  output logic [$clog2(QUEUE_DEPTH):0]  rd_pending
);

  localparam int IW = `AXI_ID_WIDTH;
  localparam int AW = `AXI_ADDR_WIDTH;
  localparam int DW = `AXI_DATA_WIDTH;
  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(QUEUE_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  logic [IW-1:0] id_mem   [QUEUE_DEPTH];
  logic [AW-1:0] addr_mem [QUEUE_DEPTH];
`ifdef EASY_AXI_SLV_ALIGN_CHECK_EN
  logic          err_mem  [QUEUE_DEPTH];
`endif

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  state_t        state;
  logic [3:0]    wait_cnt;

  logic          push;
  logic          pop;
  logic [IW-1:0] head_id;
  logic [DW-1:0] head_data;
  logic [1:0]    head_resp;

  // arready looks only at the registered count, so a pop never opens it in the same cycle.
  assign axi_slv_arready = (count != FULL);
  assign push            = axi_slv_arvalid && axi_slv_arready;
  assign pop             = axi_slv_rvalid && axi_slv_rready;
  assign axi_slv_rlast   = axi_slv_rvalid;
  assign rd_pending      = count;

  assign head_id = id_mem[rd_ptr];

`ifdef EASY_AXI_SLV_ALIGN_CHECK_EN
  assign head_resp = err_mem[rd_ptr] ? 2'b10 : 2'b00;
  assign head_data = err_mem[rd_ptr] ? '0 : (DW'(addr_mem[rd_ptr]) + DW'(head_id));
`else
  assign head_resp = 2'b00;
  assign head_data = DW'(addr_mem[rd_ptr]) + DW'(head_id);
`endif

  always_ff @(posedge clk) begin
    if (push) begin
      id_mem[wr_ptr]   <= axi_slv_arid;
      addr_mem[wr_ptr] <= axi_slv_araddr;
`ifdef EASY_AXI_SLV_ALIGN_CHECK_EN
      err_mem[wr_ptr]  <= (axi_slv_araddr[1:0] != 2'b00);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // The head entry cannot move while the FSM is outside RESP, so it is sampled on entry to RESP.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      wait_cnt       <= '0;
      axi_slv_rvalid <= 1'b0;
      axi_slv_rid    <= '0;
      axi_slv_rdata  <= '0;
      axi_slv_rresp  <= 2'b00;
    end else begin
      case (state)
        ST_IDLE: begin
          if (count != '0) begin
            state    <= ST_WAIT;
            wait_cnt <= 4'(RD_LATENCY - 1);
          end
        end
        ST_WAIT: begin
          if (wait_cnt == '0) begin
            state          <= ST_RESP;
            axi_slv_rvalid <= 1'b1;
            axi_slv_rid    <= head_id;
            axi_slv_rdata  <= head_data;
            axi_slv_rresp  <= head_resp;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        ST_RESP: begin
          if (axi_slv_rready) begin
            state          <= ST_IDLE;
            axi_slv_rvalid <= 1'b0;
          end
        end
        default: begin
          state          <= ST_IDLE;
          axi_slv_rvalid <= 1'b0;
        end
      endcase
    end
  end

endmodule
